// File: rtl/fft_twf_pkg.sv
// Shared definitions for the FFT twiddle-factor blocks.
//   bitrev     : reverse the low 'w' bits of a value
//   qcos       : one entry of the quarter-wave cosine table,
//                round(2^frac * cos(2*pi*r/n)), round half away from zero,
//                computed in integer fixed point so it folds at elaboration
//   quad_e     : quadrant of the twiddle exponent (top two exponent bits)
//   seq_state_e: auto-sequencer states
package fft_twf_pkg;

  typedef enum logic [1:0] {
    QUAD0 = 2'd0,   // ( a, -b)
    QUAD1 = 2'd1,   // (-b, -a)
    QUAD2 = 2'd2,   // (-a,  b)
    QUAD3 = 2'd3    // ( b,  a)
  } quad_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  localparam int     TRIG_FB = 30;
  // pi in Q30
  localparam longint PI_Q30  = 64'sd3373259426;

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned w);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < w; i++) begin
      res = (res << 1) | ((v >> i) & 32'd1);
    end
    return res;
  endfunction

  // Taylor series of cos(x), x in [0, pi/2], Q30 arithmetic. The end points
  // are returned exactly so truncation error can never flip them.
  function automatic int qcos(input int n, input int frac, input int r);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    if (r == 0) return (1 << frac);
    if (4 * r == n) return 0;
    x    = (2 * PI_Q30 * longint'(r)) / longint'(n);
    x2   = (x * x) >>> TRIG_FB;
    term = 64'sd1 <<< TRIG_FB;
    sum  = term;
    for (int k = 1; k <= 12; k++) begin
      term = (-((term * x2) >>> TRIG_FB)) / longint'((2 * k - 1) * (2 * k));
      sum  = sum + term;
    end
    scaled = (sum <<< frac) + (64'sd1 <<< (TRIG_FB - 1));
    return int'(scaled >>> TRIG_FB);
  endfunction

endpackage

// File: rtl/twf_qtable.sv
// Quarter-wave cosine table, N/4+1 entries, with two registered read ports.
//   i_clk    : clock
//   i_addr_a : read address, port A (0..N/4)
//   i_addr_b : read address, port B (0..N/4)
//   o_a, o_b : signed table values, one cycle after the address
module twf_qtable
  import fft_twf_pkg::*;
#(
  parameter  int N       = 64,
  parameter  int FRAC    = 7,
  parameter  int W_WIDTH = 10,
  localparam int QN      = N / 4,
  localparam int QW      = $clog2(QN) + 1
) (
  input  logic                      i_clk,
  input  logic [QW-1:0]             i_addr_a,
  input  logic [QW-1:0]             i_addr_b,
  output logic signed [W_WIDTH-1:0] o_a,
  output logic signed [W_WIDTH-1:0] o_b
);

  logic signed [W_WIDTH-1:0] w_tab [QN+1];
  logic signed [W_WIDTH-1:0] r_a;
  logic signed [W_WIDTH-1:0] r_b;

  for (genvar g = 0; g <= QN; g++) begin : g_tab
    localparam int CV = qcos(N, FRAC, g);
    assign w_tab[g] = W_WIDTH'(CV);
  end

  always_ff @(posedge i_clk) begin
    r_a <= w_tab[i_addr_a];
    r_b <= w_tab[i_addr_b];
  end

  assign o_a = r_a;
  assign o_b = r_b;

endmodule

// File: rtl/twf_gen.sv
// Twiddle-factor generator for one FFT stage. Entry (row, col) of the
// ROWS x COLS grid returns W_N^e, e = bitrev(row)*col mod N, rebuilt from a
// quarter-wave cosine table. Three-cycle pipeline, one request per cycle.
//   i_clk       : clock
//   i_rst_n     : synchronous active-low reset
//   i_valid     : external lookup request (dropped while sequencer busy)
//   i_addr      : {row, col}
//   i_inverse   : 1 = conjugate output
//   i_seq_start : pulse, starts an auto-sweep of addr 0..N-1
//   o_seq_busy  : sequencer issuing
//   o_valid     : o_w_re/o_w_im valid
//   o_last      : final coefficient of a sweep
//   o_w_re/im   : signed coefficient, 1.0 = 2^FRAC
//
// Sequencer states
//   state    | meaning
//   SEQ_IDLE | external requests pass through; waits for i_seq_start
//   SEQ_RUN  | issues addr = cnt each cycle, last on cnt = N-1
module twf_gen
  import fft_twf_pkg::*;
#(
  parameter  int N       = 64,
  parameter  int ROWS    = 8,
  parameter  int W_WIDTH = 10,
  parameter  int FRAC    = 7,
  localparam int ADDR_W  = $clog2(N),
  localparam int COLS    = N / ROWS,
  localparam int RB      = $clog2(ROWS),
  localparam int CB      = $clog2(COLS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [ADDR_W-1:0]         i_addr,
  input  logic                      i_inverse,
  input  logic                      i_seq_start,
  output logic                      o_seq_busy,
  output logic                      o_valid,
  output logic                      o_last,
  output logic signed [W_WIDTH-1:0] o_w_re,
  output logic signed [W_WIDTH-1:0] o_w_im
);

  localparam int QN = N / 4;
  localparam int QW = ADDR_W - 1;
  localparam logic [QW-1:0] QN_ADDR = QW'(QN);

  // ---------------- sequencer ----------------
  seq_state_e        r_state;
  seq_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_seq_inv;
  logic              w_seq_inv_nxt;

  logic              w_req_valid;
  logic              w_req_last;
  logic              w_req_inv;
  logic [ADDR_W-1:0] w_req_addr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= SEQ_IDLE;
      r_cnt     <= '0;
      r_seq_inv <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_seq_inv <= w_seq_inv_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_seq_inv_nxt = r_seq_inv;
    w_req_valid   = 1'b0;
    w_req_last    = 1'b0;
    w_req_inv     = i_inverse;
    w_req_addr    = i_addr;
    case (r_state)
      SEQ_IDLE: begin
        // a start in the same cycle as an external request wins
        if (i_seq_start) begin
          w_state_nxt   = SEQ_RUN;
          w_cnt_nxt     = '0;
          w_seq_inv_nxt = i_inverse;
        end else begin
          w_req_valid = i_valid;
        end
      end
      SEQ_RUN: begin
        w_req_valid = 1'b1;
        w_req_addr  = r_cnt;
        w_req_inv   = r_seq_inv;
        w_cnt_nxt   = r_cnt + ADDR_W'(1);
        if (r_cnt == ADDR_W'(N - 1)) begin
          w_req_last  = 1'b1;
          w_state_nxt = SEQ_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  assign o_seq_busy = (r_state == SEQ_RUN);

  // ---------------- S1: exponent ----------------
  logic [RB-1:0]     w_row;
  logic [CB-1:0]     w_col;
  logic [ADDR_W-1:0] w_row_rev;
  logic [ADDR_W-1:0] w_e;

  assign w_row     = w_req_addr[ADDR_W-1:CB];
  assign w_col     = w_req_addr[CB-1:0];
  assign w_row_rev = ADDR_W'(bitrev(32'(w_row), RB));
  // ADDR_W-wide product wraps, giving mod N for free
  assign w_e       = w_row_rev * ADDR_W'(w_col);

  logic              r_s1_valid;
  logic              r_s1_last;
  logic              r_s1_inv;
  logic [ADDR_W-1:0] r_s1_e;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= w_req_valid;
      r_s1_last  <= w_req_last;
    end
  end

  always_ff @(posedge i_clk) begin
    r_s1_inv <= w_req_inv;
    r_s1_e   <= w_e;
  end

  // ---------------- S2: table reads ----------------
  logic [ADDR_W-3:0]         w_r;
  logic [QW-1:0]             w_addr_a;
  logic [QW-1:0]             w_addr_b;
  logic signed [W_WIDTH-1:0] w_a;
  logic signed [W_WIDTH-1:0] w_b;

  assign w_r      = r_s1_e[ADDR_W-3:0];
  assign w_addr_a = {1'b0, w_r};
  assign w_addr_b = QN_ADDR - {1'b0, w_r};

  twf_qtable #(
    .N       (N),
    .FRAC    (FRAC),
    .W_WIDTH (W_WIDTH)
  ) u_qtable (
    .i_clk    (i_clk),
    .i_addr_a (w_addr_a),
    .i_addr_b (w_addr_b),
    .o_a      (w_a),
    .o_b      (w_b)
  );

  logic  r_s2_valid;
  logic  r_s2_last;
  logic  r_s2_inv;
  quad_e r_s2_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
    end
  end

  always_ff @(posedge i_clk) begin
    r_s2_inv <= r_s1_inv;
    r_s2_q   <= quad_e'(r_s1_e[ADDR_W-1:ADDR_W-2]);
  end

  // ---------------- S3: quadrant mapping, conjugate ----------------
  logic signed [W_WIDTH-1:0] w_re_map;
  logic signed [W_WIDTH-1:0] w_im_map;
  logic signed [W_WIDTH-1:0] w_im_fin;

  always_comb begin
    w_re_map = w_a;
    w_im_map = -w_b;
    case (r_s2_q)
      QUAD0: begin w_re_map =  w_a; w_im_map = -w_b; end
      QUAD1: begin w_re_map = -w_b; w_im_map = -w_a; end
      QUAD2: begin w_re_map = -w_a; w_im_map =  w_b; end
      QUAD3: begin w_re_map =  w_b; w_im_map =  w_a; end
      default: ;
    endcase
    w_im_fin = r_s2_inv ? -w_im_map : w_im_map;
  end

  logic                      r_out_valid;
  logic                      r_out_last;
  logic signed [W_WIDTH-1:0] r_w_re;
  logic signed [W_WIDTH-1:0] r_w_im;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_w_re      <= '0;
      r_w_im      <= '0;
    end else begin
      r_out_valid <= r_s2_valid;
      r_out_last  <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        r_w_re <= w_re_map;
        r_w_im <= w_im_fin;
      end
    end
  end

  assign o_valid = r_out_valid;
  assign o_last  = r_out_last;
  assign o_w_re  = r_w_re;
  assign o_w_im  = r_w_im;

endmodule

// File: doc/twf_gen.md
Name: twf_gen

Overview:
- Parametrised twiddle-factor generator for a stage of the pipelined FFT; the next generation of the fixed per-stage twiddle ROMs.
- Addressed as a ROWS x COLS grid. Entry (row, col) returns W_N^e with e = bitrev(row)*col mod N.
- Stores only a quarter-wave cosine table and rebuilds the other quadrants by symmetry.
- Supports a forward/inverse (conjugate) mode and an internal auto-sequencer that streams one full stage's coefficient set.

Parameters:
- N, 64, FFT size; power of 2, >= 16.
- ROWS, 8, grid rows; power of 2 dividing N. Derived COLS = N/ROWS.
- W_WIDTH, 10, signed coefficient width.
- FRAC, 7, fractional bits; 1.0 = 2^FRAC (128).
- Derived ADDR_W = log2(N), RB = log2(ROWS), CB = log2(COLS).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  external lookup request; ignored while seq_busy
- addr  in  ADDR_W  {row[RB-1:0], col[CB-1:0]}
- inverse  in  1  1 = conjugate output (IFFT); sampled together with the request
- seq_start  in  1  one-cycle pulse; starts an auto-sweep of addr 0..N-1
- seq_busy  out  1  high while the sequencer is issuing
- out_valid  out  1  w_re/w_im valid
- out_last  out  1  with out_valid on the final sequenced coefficient
- w_re  out  W_WIDTH  signed real part
- w_im  out  W_WIDTH  signed imaginary part

Behaviour:
- Table: C[r] = round(2^FRAC * cos(2*pi*r/N)) for r = 0..N/4, with N/4+1 entries. Round half away from zero. The table is an elaboration-time constant.
- Pipeline, latency 3 cycles, one request per cycle, no back-pressure:
  - S1: register the request and compute e = (bitrev_RB(row) * col) mod N.
  - S2: q = e[ADDR_W-1:ADDR_W-2], r = e mod N/4. Register a = C[r] and b = C[N/4-r] (two reads).
  - S3: apply the quadrant mapping, then conjugate if inverse, then register the outputs.
- Quadrant mapping:
  - q0: (a, -b)
  - q1: (-b, -a)
  - q2: (-a, b)
  - q3: (b, a)
- Negation is full-width. The magnitude never exceeds 2^FRAC, so it cannot overflow when W_WIDTH >= FRAC+3.
- Sequencer FSM:
  - IDLE: on seq_start, go to RUN with cnt = 0.
  - RUN: issue addr = cnt with the inverse value latched at start. cnt++ each cycle. At cnt = N-1, tag the request "last" and return to IDLE.
  - seq_busy = (state == RUN).
  - seq_start while RUN is ignored. in_valid while RUN is dropped.
  - seq_start and in_valid in the same IDLE cycle: the sequencer wins and the external request is dropped.
- The output stream is back-to-back: N consecutive out_valid cycles. out_last is asserted only on the N-th.
- When out_valid = 0, w_re/w_im hold their last value.
- Reset (any cycle, including mid-sweep):
  - state = IDLE, cnt = 0, all stage valids = 0.
  - out_valid = 0, out_last = 0, seq_busy = 0, w_re = 0, w_im = 0.
  - In-flight requests are discarded.

Decomposition:
- Package fft_twf_pkg holds:
  - the bitrev function;
  - the quarter-cosine table generator function, parametrised by N and FRAC;
  - the quadrant mapping encoding.
- One sub-module, twf_qtable: quarter-wave table with two registered read ports. It provides S2 and is reusable by other stages.
- Sequencer and sign logic stay in the top level.

Test Plan:
- Reset, then in_valid for addr 0..7 -> out_valid 3 cycles later for 8 cycles. Every output (128, 0).
- addr 9 -> e = 4 -> (118, -49).
- addr 63 -> e = 49 (q3, r = 1) -> (13, 127).
- addr 12 with inverse = 1 -> e = 16 -> forward value (0, -128), so the output is (0, 128).
- seq_start pulse -> seq_busy high for 64 cycles, then 64 contiguous out_valid cycles. out_last only on the 64th, whose value is (13, 127). in_valid pulses during the sweep produce no extra outputs. A second seq_start mid-sweep is ignored.
- rst_n low at the 20th sweep cycle -> out_valid, seq_busy and out_last all 0 from the next edge, outputs 0. No residual outputs after release.
- Sweep all 64 addr values, forward and inverse, against a real-math model -> exact match.
